wav_play_ctrl: RTL and testbench

//  Playback sequencer between the SD byte reader and the WM8731 DAC serializer.

---
 rtl/wav_play_ctrl_pkg.sv | 28 ++
 rtl/wav_play_ctrl_if.sv | 23 ++
 rtl/wav_sample_fifo.sv | 60 ++++++
 rtl/wav_play_ctrl.sv | 163 ++++++++++++++++
 tb/tb_wav_play_ctrl.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/wav_play_ctrl_pkg.sv
// Package wav_play_pkg: shared types and constants for the .wav playback sequencer.
//   state_t      - sequencer FSM states
//   MAGIC_*      - RIFF/WAVE header magic words (byte 0 of the file in bits [31:24])
//   *_OFS        - byte offsets of the magic words inside the header
//   SIZE_FIELD_BYTES - width of the little-endian data-size field at the end of the header
package wav_play_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StData,
    StDrain,
    StDone,
    StErr
  } state_t;

  localparam logic [31:0] MAGIC_RIFF       = 32'h5249_4646;  // "RIFF"
  localparam logic [31:0] MAGIC_WAVE       = 32'h5741_5645;  // "WAVE"
  localparam int unsigned RIFF_OFS         = 0;
  localparam int unsigned WAVE_OFS         = 8;
  localparam int unsigned SIZE_FIELD_BYTES = 4;

  // Byte idx (0 = first in file) of a 4-character magic word.
  function automatic logic [7:0] magic_byte(input logic [31:0] m, input logic [1:0] idx);
    return m[8*(3-int'(idx)) +: 8];
  endfunction

endpackage

// File: rtl/wav_play_ctrl_if.sv
// Interface wav_play_ctrl_if: byte stream from the SD reader and the sample port to the
// DAC serializer.
//   byte_data/byte_valid/byte_ready - byte stream, transfer on byte_valid & byte_ready
//   myvalid                         - serializer sample request pulse
//   wav_data                        - current 16-bit sample to the serializer
// Modports: slave = sequencer side, master = reader/serializer (or testbench) side.
interface wav_play_ctrl_if;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic        byte_ready;
  logic        myvalid;
  logic [15:0] wav_data;

  modport master (
    output byte_data, byte_valid, myvalid,
    input  byte_ready, wav_data
  );

  modport slave (
    input  byte_data, byte_valid, myvalid,
    output byte_ready, wav_data
  );
endinterface

// File: rtl/wav_sample_fifo.sv
// wav_sample_fifo: synchronous 16-bit sample FIFO with first-word fall-through read.
// Ports:
//   clk50M, rst        - clock, synchronous active-high reset
//   i_clr              - synchronous flush
//   i_push, i_wdata    - write (ignored when full)
//   i_pop, o_rdata     - read; o_rdata shows the head word while not empty
//   o_full, o_empty    - status
//   o_count            - occupancy, $clog2(DEPTH)+1 bits
// Same-cycle push and pop is allowed and leaves the count unchanged.
module wav_sample_fifo #(
  parameter int unsigned DEPTH = 256
) (
  input  logic                     clk50M,
  input  logic                     rst,
  input  logic                     i_clr,
  input  logic                     i_push,
  input  logic [15:0]              i_wdata,
  input  logic                     i_pop,
  output logic [15:0]              o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [15:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_push;
  logic          w_do_pop;

  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];
  assign w_do_push = i_push & ~o_full;
  assign w_do_pop  = i_pop & ~o_empty;

  // Storage carries no reset; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk50M) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  always_ff @(posedge clk50M) begin
    if (rst || i_clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/wav_play_ctrl.sv
// wav_play_ctrl: playback sequencer between the SD byte reader and the WM8731 serializer.
// Skips (optionally checks) the RIFF header, pairs little-endian PCM bytes into 16-bit
// samples, buffers them in wav_sample_fifo and serves one sample per myvalid request.
// Ports:
//   clk50M, rst  - clock, synchronous active-high reset
//   start        - begin a new file (honoured in IDLE or ERR)
//   bus          - wav_play_ctrl_if.slave: byte stream in, sample port out
//   busy         - state != IDLE
//   done         - one-cycle pulse when playback completes
//   underrun     - sticky, request hit an empty FIFO during DATA; cleared on start
//   hdr_err      - sticky, header magic mismatch; cleared on start
// Build option: define WAV_HDR_CHECK_EN to check "RIFF"/"WAVE" magic; otherwise header
// bytes before the size field are discarded and hdr_err stays 0.
module wav_play_ctrl
  import wav_play_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 256,
  parameter int unsigned HDR_BYTES  = 44
) (
  input  logic             clk50M,
  input  logic             rst,
  input  logic             start,
  wav_play_ctrl_if.slave   bus,
  output logic             busy,
  output logic             done,
  output logic             underrun,
  output logic             hdr_err
);
  state_t      r_state;
  state_t      w_state_d;
  logic [15:0] r_hcnt;
  logic [31:0] r_rem;
  logic [7:0]  r_lo;
  logic        r_phase;     // 1 when the next data byte is the high byte
  logic [15:0] r_wav;
  logic        r_underrun;
  logic        r_hdr_err;

  logic                          w_byte_ready;
  logic                          w_xfer;
  logic                          w_start;
  logic                          w_push;
  logic                          w_pop;
  logic                          w_magic_bad;
  logic                          w_size_fld;
  logic [31:0]                   w_size_full;
  logic [15:0]                   w_rdata;
  logic                          w_full;
  logic                          w_empty;
  logic [$clog2(FIFO_DEPTH):0]   w_count;

  assign w_xfer      = bus.byte_valid & w_byte_ready;
  assign w_start     = start & ((r_state == StIdle) | (r_state == StErr));
  // A start in the same cycle as myvalid wins; that pop is discarded.
  assign w_pop       = bus.myvalid & ~w_start;
  assign w_size_fld  = (r_hcnt >= 16'(HDR_BYTES - SIZE_FIELD_BYTES));
  // Size as it will be once the current (last) header byte is shifted in.
  assign w_size_full = {bus.byte_data, r_rem[31:8]};

`ifdef WAV_HDR_CHECK_EN
  always_comb begin
    w_magic_bad = 1'b0;
    if (r_hcnt < 16'(RIFF_OFS + 4)) begin
      w_magic_bad = (bus.byte_data != magic_byte(MAGIC_RIFF, r_hcnt[1:0]));
    end else if (r_hcnt >= 16'(WAVE_OFS) && r_hcnt < 16'(WAVE_OFS + 4)) begin
      w_magic_bad = (bus.byte_data != magic_byte(MAGIC_WAVE, r_hcnt[1:0]));
    end
  end
`else
  assign w_magic_bad = 1'b0;
`endif

  wav_sample_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk50M  (clk50M),
    .rst     (rst),
    .i_clr   (w_start),
    .i_push  (w_push),
    .i_wdata ({bus.byte_data, r_lo}),
    .i_pop   (w_pop),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_state_d    = r_state;
    w_byte_ready = 1'b0;
    w_push       = 1'b0;
    unique case (r_state)
      StIdle: if (w_start) w_state_d = StHdr;
      StHdr: begin
        w_byte_ready = 1'b1;
        if (w_xfer) begin
          if (w_magic_bad) begin
            w_state_d = StErr;
          end else if (r_hcnt == 16'(HDR_BYTES - 1)) begin
            w_state_d = (w_size_full == '0) ? StDone : StData;
          end
        end
      end
      StData: begin
        w_byte_ready = ~w_full & (r_rem != '0);
        w_push       = w_xfer & r_phase;
        if (r_rem == '0) w_state_d = StDrain;
      end
      StDrain: if (w_count == '0) w_state_d = StDone;
      StDone:  w_state_d = StIdle;
      StErr:   if (w_start) w_state_d = StHdr;
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk50M) begin
    if (rst) begin
      r_state    <= StIdle;
      r_hcnt     <= '0;
      r_rem      <= '0;
      r_lo       <= '0;
      r_phase    <= 1'b0;
      r_wav      <= '0;
      r_underrun <= 1'b0;
      r_hdr_err  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_start) begin
        r_hcnt     <= '0;
        r_rem      <= '0;
        r_phase    <= 1'b0;
        r_underrun <= 1'b0;
        r_hdr_err  <= 1'b0;
      end else begin
        if (r_state == StHdr && w_xfer) begin
          r_hcnt <= r_hcnt + 16'd1;
          if (w_size_fld)  r_rem     <= w_size_full;
          if (w_magic_bad) r_hdr_err <= 1'b1;
        end
        if (r_state == StData && w_xfer) begin
          r_rem   <= r_rem - 32'd1;
          r_phase <= ~r_phase;
          if (!r_phase) r_lo <= bus.byte_data;
        end
        if (bus.myvalid) begin
          if (!w_empty) begin
            r_wav <= w_rdata;
          end else begin
            r_wav <= '0;
            if (r_state == StData) r_underrun <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.byte_ready = w_byte_ready;
  assign bus.wav_data   = r_wav;
  assign busy           = (r_state != StIdle);
  assign done           = (r_state == StDone);
  assign underrun       = r_underrun;
  assign hdr_err        = r_hdr_err;
endmodule

// File: tb/tb_wav_play_ctrl.sv
// Testbench for wav_play_ctrl: directed vectors, expected samples queued by the stimulus
// and compared by a monitor whenever a myvalid request has been served.
// A second instance with a 4-word FIFO exercises backpressure.
module tb_wav_play_ctrl;
  logic clk50M = 1'b0;
  always #10 clk50M = ~clk50M;

  logic rst;
  logic start, start4;
  logic busy, done, underrun, hdr_err;
  logic busy4, done4, underrun4, hdr_err4;

  wav_play_ctrl_if bif ();
  wav_play_ctrl_if bif4 ();

  wav_play_ctrl #(.FIFO_DEPTH(256), .HDR_BYTES(44)) dut (
    .clk50M   (clk50M),
    .rst      (rst),
    .start    (start),
    .bus      (bif.slave),
    .busy     (busy),
    .done     (done),
    .underrun (underrun),
    .hdr_err  (hdr_err)
  );

  wav_play_ctrl #(.FIFO_DEPTH(4), .HDR_BYTES(44)) dut4 (
    .clk50M   (clk50M),
    .rst      (rst),
    .start    (start4),
    .bus      (bif4.slave),
    .busy     (busy4),
    .done     (done4),
    .underrun (underrun4),
    .hdr_err  (hdr_err4)
  );

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(negedge clk50M) if (done === 1'b1) done_cnt++;

  // Monitor: a request seen at a rising edge is answered on wav_data right after it.
  initial begin
    forever begin
      @(posedge clk50M);
      if (bif.myvalid === 1'b1) begin
        @(negedge clk50M);
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wav_data: got %0h with no expected sample queued", bif.wav_data);
        end else begin
          check("wav_data", bif.wav_data, exp_q.pop_front());
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk50M);
      bif.byte_valid = 1'b0;
      bif.myvalid    = 1'b0;
      start          = 1'b0;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk50M);
    start = 1'b1; bif.byte_valid = 1'b0; bif.myvalid = 1'b0;
    @(negedge clk50M);
    start = 1'b0;
  endtask

  task automatic pulse_mv(input logic [15:0] exp);
    @(negedge clk50M);
    bif.myvalid = 1'b1; bif.byte_valid = 1'b0;
    exp_q.push_back(exp);
    @(negedge clk50M);
    bif.myvalid = 1'b0;
  endtask

  // Offers one byte and returns after the edge that transfers it.
  task automatic send_byte(input logic [7:0] b);
    int waited = 0;
    @(negedge clk50M);
    bif.byte_data = b; bif.byte_valid = 1'b1; bif.myvalid = 1'b0;
    forever begin
      #1;
      if (bif.byte_ready === 1'b1) begin
        @(posedge clk50M);
        break;
      end
      waited++;
      if (waited > 200) begin
        total++;
        bad++;
        $display("FAIL byte_stall: byte %0h not accepted, got ready=0 want 1", b);
        break;
      end
      @(negedge clk50M);
    end
  endtask

  function automatic logic [7:0] hdr_byte(input int i, input logic [31:0] size,
                                          input logic [31:0] m0);
    logic [31:0] wave;
    wave = "WAVE";
    if (i < 4) return m0[8*(3-i) +: 8];
    if (i >= 8 && i < 12) return wave[8*(11-i) +: 8];
    if (i >= 40) return size[8*(i-40) +: 8];
    return 8'h00;
  endfunction

  task automatic send_header(input logic [31:0] size, input logic [31:0] m0);
    for (int i = 0; i < 44; i++) send_byte(hdr_byte(i, size, m0));
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk50M);
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk50M);
      n++;
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL wait_idle: got busy=1 want 0 within 500 cycles");
    end
  endtask

  initial begin
    int d0;
    int k;
    rst = 1'b1; start = 1'b0; start4 = 1'b0;
    bif.byte_data = '0; bif.byte_valid = 1'b0; bif.myvalid = 1'b0;
    bif4.byte_data = '0; bif4.byte_valid = 1'b0; bif4.myvalid = 1'b0;
    repeat (3) @(negedge clk50M);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", bif.byte_ready, 0);
    check("rst_wav", bif.wav_data, 0);
    check("rst_underrun", underrun, 0);
    check("rst_hdr_err", hdr_err, 0);
    rst = 1'b0;
    idle(2);

    // Nominal playback, size 8
    pulse_start();
    check("t2_busy", busy, 1);
    send_header(32'd8, "RIFF");
    send_byte(8'h01); send_byte(8'h00); send_byte(8'hFF); send_byte(8'h7F);
    send_byte(8'h00); send_byte(8'h80); send_byte(8'h34); send_byte(8'h12);
    idle(1);
    d0 = done_cnt;
    pulse_mv(16'h0001); pulse_mv(16'h7FFF); pulse_mv(16'h8000); pulse_mv(16'h1234);
    wait_idle();
    idle(2);
    check("t2_done_once", done_cnt - d0, 1);
    check("t2_busy_low", busy, 0);
    check("t2_wav_held", bif.wav_data, 16'h1234);
    check("t2_underrun", underrun, 0);

    // Underrun in DATA
    pulse_start();
    send_header(32'd4, "RIFF");
    idle(1);
    pulse_mv(16'h0000);
    check("t4_underrun_set", underrun, 1);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    idle(1);
    pulse_mv(16'h2211); pulse_mv(16'h4433);
    wait_idle();
    check("t4_underrun_sticky", underrun, 1);

    // Odd size: final byte dropped
    pulse_start();
    check("t5_underrun_clr", underrun, 0);
    d0 = done_cnt;
    send_header(32'd3, "RIFF");
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    idle(1);
    pulse_mv(16'hBBAA);
    wait_idle();
    check("t5_done", done_cnt - d0, 1);
    pulse_mv(16'h0000);   // empty request in IDLE: zero, no flag
    check("t5_idle_no_underrun", underrun, 0);

    // Zero-size file goes straight to DONE
    pulse_start();
    d0 = done_cnt;
    send_header(32'd0, "RIFF");
    wait_idle();
    check("size0_done", done_cnt - d0, 1);

`ifdef WAV_HDR_CHECK_EN
    pulse_start();
    send_byte("R"); send_byte("I"); send_byte("F"); send_byte("X");
    idle(2);
    check("t6_hdr_err", hdr_err, 1);
    check("t6_busy_err", busy, 1);
    check("t6_ready_low", bif.byte_ready, 0);
    pulse_start();
    check("t6_hdr_err_clr", hdr_err, 0);
    send_header(32'd2, "RIFF");
    send_byte(8'h5A); send_byte(8'hA5);
    idle(1);
    pulse_mv(16'hA55A);
    wait_idle();
`else
    pulse_start();
    d0 = done_cnt;
    send_header(32'd0, "RIFX");
    wait_idle();
    check("nochk_hdr_err", hdr_err, 0);
    check("nochk_done", done_cnt - d0, 1);
`endif

    // Reset mid-DATA with 10 samples queued
    pulse_start();
    send_header(32'd40, "RIFF");
    for (int i = 0; i < 22; i++) send_byte(8'(i));
    idle(1);
    pulse_mv(16'h0100);
    check("t1_pre_busy", busy, 1);
    @(negedge clk50M);
    rst = 1'b1;
    @(negedge clk50M);
    check("t1_busy", busy, 0);
    check("t1_wav", bif.wav_data, 0);
    check("t1_ready", bif.byte_ready, 0);
    check("t1_fifo_empty", dut.w_count, 0);
    rst = 1'b0;
    idle(2);

    // Backpressure on the 4-deep instance, size 20, no requests
    @(negedge clk50M);
    start4 = 1'b1;
    @(negedge clk50M);
    start4 = 1'b0;
    for (int i = 0; i < 44; i++) begin
      @(negedge clk50M);
      bif4.byte_data = hdr_byte(i, 32'd20, "RIFF");
      bif4.byte_valid = 1'b1;
    end
    k = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk50M);
      bif4.byte_data = 8'(k);
      #1;
      if (bif4.byte_ready === 1'b1) k++;
    end
    check("t3_bytes_before_full", k, 8);
    check("t3_ready_low", bif4.byte_ready, 0);
    @(negedge clk50M);
    bif4.myvalid = 1'b1;
    #1;
    check("t3_ready_still_low", bif4.byte_ready, 0);
    @(negedge clk50M);
    bif4.myvalid = 1'b0;
    #1;
    check("t3_ready_resumed", bif4.byte_ready, 1);
    check("t3_first_sample", bif4.wav_data, 16'h0100);
    @(negedge clk50M);
    bif4.byte_valid = 1'b0;
    idle(3);

    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL exp_q_left: got %0d pending want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
